// File: rtl/bist_pkg.sv
// Shared types and widths for the logic-BIST sequencer.
package bist_pkg;

  localparam int SHIFT_CNT_W   = 10;
  localparam int PATTERN_CNT_W = 16;
  localparam int SIG_W         = 7;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPTURE,
    UNLOAD,
    COMPARE,
    DONE
  } bist_state_e;

endpackage

// File: rtl/bist_cycle_counter.sv
// Loadable up-counter with a terminal-count flag against a programmable terminal value.
module bist_cycle_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (en)
      count <= count + 1'b1;
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/bist_controller.sv
// Logic-BIST run sequencer: init, shift/capture loop, final unload, signature compare.
// state   | meaning
// IDLE    | waiting for start, all controls low
// INIT    | reset TPG and compactor, clear counters
// SHIFT   | load next pattern while compacting previous response
// CAPTURE | single functional capture, count pattern
// UNLOAD  | flush last response into the compactor
// COMPARE | register pass from the compactor signature
// DONE    | result held until start or abort
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned      CHAIN_LEN    = 33,
  parameter int unsigned      NUM_PATTERNS = 128,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = 7'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SIG_W-1:0]         signature,
  output logic                     tpg_reset,
  output logic                     comp_reset,
  output logic                     comp_en,
  output logic                     bist_en,
  output logic                     scan_en,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [PATTERN_CNT_W-1:0] pattern_cnt
);

  localparam logic [SHIFT_CNT_W-1:0]   SHIFT_LAST   = SHIFT_CNT_W'(CHAIN_LEN - 1);
  localparam logic [PATTERN_CNT_W-1:0] PATTERN_LAST = PATTERN_CNT_W'(NUM_PATTERNS - 1);

  bist_state_e state, state_nxt;

  logic shift_load, shift_en, shift_tc;
  logic pat_load, pat_en, pat_tc;
  logic pass_clr;
  // Shift position is only consumed through its terminal flag.
  logic [SHIFT_CNT_W-1:0] shift_cnt_unused;

  bist_cycle_counter #(.WIDTH(SHIFT_CNT_W)) u_shift_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (shift_load),
    .load_value ('0),
    .en         (shift_en),
    .terminal   (SHIFT_LAST),
    .count      (shift_cnt_unused),
    .tc         (shift_tc)
  );

  bist_cycle_counter #(.WIDTH(PATTERN_CNT_W)) u_pattern_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (pat_load),
    .load_value ('0),
    .en         (pat_en),
    .terminal   (PATTERN_LAST),
    .count      (pattern_cnt),
    .tc         (pat_tc)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    shift_load = 1'b0;
    shift_en   = 1'b0;
    pat_load   = 1'b0;
    pat_en     = 1'b0;
    pass_clr   = 1'b0;
    tpg_reset  = 1'b0;
    comp_reset = 1'b0;
    comp_en    = 1'b0;
    bist_en    = 1'b0;
    scan_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: ;
      INIT: begin
        tpg_reset  = 1'b1;
        comp_reset = 1'b1;
        bist_en    = 1'b1;
        busy       = 1'b1;
      end
      SHIFT, UNLOAD: begin
        scan_en = 1'b1;
        bist_en = 1'b1;
        comp_en = 1'b1;
        busy    = 1'b1;
      end
      CAPTURE: begin
        bist_en = 1'b1;
        busy    = 1'b1;
      end
      COMPARE: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase

    // Abort outranks start and every sequencing decision.
    if (abort) begin
      state_nxt  = IDLE;
      shift_load = 1'b1;
      pat_load   = 1'b1;
      pass_clr   = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt  = INIT;
            shift_load = 1'b1;
            pat_load   = 1'b1;
            pass_clr   = 1'b1;
          end
        end
        INIT: begin
          state_nxt  = SHIFT;
          shift_load = 1'b1;
          pat_load   = 1'b1;
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (shift_tc)
            state_nxt = CAPTURE;
        end
        CAPTURE: begin
          pat_en     = 1'b1;
          shift_load = 1'b1;
          state_nxt  = pat_tc ? UNLOAD : SHIFT;
        end
        UNLOAD: begin
          shift_en = 1'b1;
          if (shift_tc)
            state_nxt = COMPARE;
        end
        COMPARE: state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pass_clr)
      pass <= 1'b0;
    else if (state == COMPARE)
      pass <= (signature == GOLDEN_SIG);
  end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller with a run-timeline reference model checked every cycle.
module tb_bist_controller;

  localparam int C = 4;
  localparam int N = 3;
  localparam logic [6:0] GS = 7'h5A;
  localparam int T_CMP = N * (C + 1) + C + 1;

  logic        clk, reset, start, abort;
  logic [6:0]  signature;
  logic        tpg_reset, comp_reset, comp_en, bist_en, scan_en, busy, done, pass;
  logic [15:0] pattern_cnt;

  int checks = 0;
  int errors = 0;

  int   m_mode = 0;  // 0 idle, 1 running, 2 done
  int   m_t = 0;     // cycles since the run entered INIT
  logic m_pass = 1'b0;
  bit   m_valid = 1'b0;

  bist_controller #(
    .CHAIN_LEN    (C),
    .NUM_PATTERNS (N),
    .GOLDEN_SIG   (GS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .signature   (signature),
    .tpg_reset   (tpg_reset),
    .comp_reset  (comp_reset),
    .comp_en     (comp_en),
    .bist_en     (bist_en),
    .scan_en     (scan_en),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .pattern_cnt (pattern_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_t = 0; m_pass = 1'b0; m_valid = 1'b1;
    end else if (abort) begin
      m_mode = 0; m_t = 0; m_pass = 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_t = 0; end
        1: begin
          if (m_t == T_CMP) begin
            m_pass = (signature == GS);
            m_mode = 2;
          end else begin
            m_t++;
          end
        end
        default: if (start) begin m_mode = 1; m_t = 0; m_pass = 1'b0; end
      endcase
    end
  end

  // {tpg_reset, comp_reset, comp_en, bist_en, scan_en, busy, done, pass, pattern_cnt}
  function automatic logic [23:0] expect_vec();
    logic [7:0]  f;
    logic [15:0] pc;
    int u, p, r;
    f = '0;
    pc = '0;
    f[0] = m_pass;
    if (m_mode == 2) begin
      f[1] = 1'b1;
      pc = 16'(N);
    end else if (m_mode == 1) begin
      f[2] = 1'b1;
      if (m_t == 0) begin
        f[7] = 1'b1; f[6] = 1'b1; f[4] = 1'b1;
      end else if (m_t <= N * (C + 1)) begin
        u = m_t - 1;
        p = u / (C + 1);
        r = u % (C + 1);
        pc = 16'(p);
        if (r < C) f[5:3] = 3'b111;
        else       f[4] = 1'b1;
      end else if (m_t <= N * (C + 1) + C) begin
        f[5:3] = 3'b111;
        pc = 16'(N);
      end else begin
        pc = 16'(N);
      end
    end
    return {f, pc};
  endfunction

  always @(negedge clk) begin
    logic [23:0] got, exp;
    if (m_valid) begin
      got = {tpg_reset, comp_reset, comp_en, bist_en, scan_en, busy, done, pass, pattern_cnt};
      exp = expect_vec();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_outputs at %0t: got %h expected %h", $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Edges counted include the one that samples start; captures are CAPTURE-shaped cycles.
  task automatic start_and_wait(output int n, output int caps);
    n = 0;
    caps = 0;
    start = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      start = 1'b0;
      n++;
      if (bist_en && !scan_en && !tpg_reset) caps++;
      if (done) break;
      if (n >= 400) begin
        errors++;
        $display("FAIL wait_done: timeout after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      n++;
      if (done) break;
      if (n >= 400) begin
        errors++;
        $display("FAIL wait_done: timeout after %0d cycles", n);
        break;
      end
    end
  endtask

  initial begin
    int n, caps;
    reset = 1'b1; start = 1'b0; abort = 1'b0; signature = GS;
    step(3);
    chk("reset_outputs", {tpg_reset, comp_reset, comp_en, bist_en, scan_en, busy, done, pass, pattern_cnt}, 32'h0);
    reset = 1'b0;
    step(2);
    chk("idle_outputs", {busy, done, pass, pattern_cnt}, 32'h0);

    // Passing run: 1 + 3*5 + 4 + 1 + 1 = 22 edges including the start edge.
    start_and_wait(n, caps);
    chk("run_length", n, 22);
    chk("capture_cycles", caps, 3);
    chk("pass_done", {done, pass}, 2'b11);
    step(3);
    chk("done_held", {done, pass, busy}, 3'b110);

    // Restart from DONE with a corrupted signature.
    signature = GS ^ 7'h01;
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("reinit_flags", {tpg_reset, comp_reset, done}, 3'b110);
    chk("reinit_pattern_cnt", pattern_cnt, 0);
    wait_done(n);
    chk("rerun_length", n, 21);
    chk("fail_done", {done, pass}, 2'b10);

    // Abort in the second SHIFT cycle of pattern 2, with start asserted alongside.
    signature = GS;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    chk("pre_abort_shift", {scan_en, pattern_cnt}, {1'b1, 16'd1});
    abort = 1'b1;
    start = 1'b1;
    step(1);
    abort = 1'b0;
    start = 1'b0;
    chk("post_abort", {busy, scan_en, bist_en, done, pass, pattern_cnt}, 32'h0);
    step(2);
    chk("abort_start_ignored", {busy, tpg_reset}, 2'b00);
    start_and_wait(n, caps);
    chk("post_abort_run_length", n, 22);
    chk("post_abort_pass", {done, pass}, 2'b11);

    // Stray starts during SHIFT, then reset during UNLOAD.
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    chk("unload_state", {scan_en, comp_en, pattern_cnt}, {2'b11, 16'd3});
    reset = 1'b1;
    step(1);
    chk("reset_mid_run", {tpg_reset, comp_reset, comp_en, bist_en, scan_en, busy, done, pass, pattern_cnt}, 32'h0);
    reset = 1'b0;
    step(1);
    start_and_wait(n, caps);
    chk("post_reset_run_length", n, 22);
    chk("post_reset_pass", {done, pass}, 2'b11);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
